// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_controller
//  Purpose  : Stall/flush sequencer for the 5-stage core: load-use bubbles,
//             memory-wait freeze and post-branch flush window.
//             Optional HAZARD_PERF_CNT_EN adds saturating event counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_controller #(
   parameter int BRANCH_PENALTY = 2,
   parameter int MEM_TIMEOUT    = 255,
   parameter int REG_IDX_W      = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REG_IDX_W-1:0] idRs1,
   input  logic [REG_IDX_W-1:0] idRs2,
   input  logic                 idUsesRs1,
   input  logic                 idUsesRs2,
   input  logic [REG_IDX_W-1:0] exRd,
   input  logic                 exRegWe,
   input  logic                 exMemRead,
   input  logic                 exPcWe,
   input  logic                 memReq,
   input  logic                 memReady,
   output logic                 stallFetch,
   output logic                 stallDecode,
   output logic                 stallExecute,
   output logic                 flushDecode,
   output logic                 flushExecute,
   output logic                 memTimeout,
   output logic [1:0]           busyState
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [15:0]          stallCycles,
   output logic [15:0]          flushCycles,
   output logic [15:0]          loadUseEvents
`endif
);

   localparam logic [1:0] c_run      = 2'd0;
   localparam logic [1:0] c_mem_wait = 2'd1;
   localparam logic [1:0] c_flush    = 2'd2;

   localparam logic [2:0] c_flush_reload    = 3'(BRANCH_PENALTY - 1);
   localparam logic [7:0] c_timeout         = 8'(MEM_TIMEOUT);
   localparam logic       c_use_flush_state = (BRANCH_PENALTY > 1);

   logic [1:0] state_q, state_d;
   logic [1:0] ret_state_q, ret_state_d;
   logic [2:0] flush_cnt_q, flush_cnt_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       mem_timeout_q, mem_timeout_d;

   logic       w_mem_busy;
   logic       w_load_use;

   assign w_mem_busy = memReq & ~memReady;
   assign w_load_use = exMemRead & exRegWe &
                       ((idUsesRs1 & (idRs1 == exRd)) | (idUsesRs2 & (idRs2 == exRd)));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= c_run;
         ret_state_q   <= c_run;
         flush_cnt_q   <= 3'd0;
         wait_cnt_q    <= 8'd0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ret_state_q   <= ret_state_d;
         flush_cnt_q   <= flush_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      ret_state_d   = ret_state_q;
      flush_cnt_d   = flush_cnt_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      case (state_q)
         c_run: begin
            if (w_mem_busy) begin
               state_d     = c_mem_wait;
               wait_cnt_d  = 8'd1;
               ret_state_d = c_run;
            end else if (exPcWe && c_use_flush_state) begin
               state_d     = c_flush;
               flush_cnt_d = c_flush_reload;
            end
         end
         c_mem_wait: begin
            if (memReady) begin
               state_d = ret_state_q;
            end else if (wait_cnt_q == c_timeout) begin
               mem_timeout_d = 1'b1;
               state_d       = ret_state_q;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         c_flush: begin
            // A wait parks the remaining flush count and resumes it afterwards
            if (w_mem_busy) begin
               state_d     = c_mem_wait;
               wait_cnt_d  = 8'd1;
               ret_state_d = c_flush;
            end else if (exPcWe) begin
               flush_cnt_d = c_flush_reload;
            end else if (flush_cnt_q == 3'd1) begin
               state_d     = c_run;
               flush_cnt_d = 3'd0;
            end else begin
               flush_cnt_d = flush_cnt_q - 3'd1;
            end
         end
         default: begin
            state_d = c_run;
         end
      endcase
   end

   always_comb begin
      stallFetch   = 1'b0;
      stallDecode  = 1'b0;
      stallExecute = 1'b0;
      flushDecode  = 1'b0;
      flushExecute = 1'b0;
      if (!reset) begin
         case (state_q)
            c_run: begin
               if (w_mem_busy) begin
                  stallFetch   = 1'b1;
                  stallDecode  = 1'b1;
                  stallExecute = 1'b1;
               end else if (exPcWe) begin
                  flushDecode  = 1'b1;
                  flushExecute = 1'b1;
               end else if (w_load_use) begin
                  stallFetch   = 1'b1;
                  stallDecode  = 1'b1;
                  flushExecute = 1'b1;
               end
            end
            c_mem_wait: begin
               if (!memReady) begin
                  stallFetch   = 1'b1;
                  stallDecode  = 1'b1;
                  stallExecute = 1'b1;
               end
            end
            c_flush: begin
               if (w_mem_busy) begin
                  stallFetch   = 1'b1;
                  stallDecode  = 1'b1;
                  stallExecute = 1'b1;
               end else begin
                  flushDecode  = 1'b1;
                  flushExecute = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign memTimeout = mem_timeout_q & ~reset;
   assign busyState  = reset ? c_run : state_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] flush_cycles_q, flush_cycles_d;
   logic [15:0] load_use_events_q, load_use_events_d;
   logic        w_load_use_stall;

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
      return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
   endfunction

   assign w_load_use_stall = (state_q == c_run) & ~w_mem_busy & ~exPcWe & w_load_use;

   always_comb begin
      stall_cycles_d    = sat_inc(stall_cycles_q, stallFetch);
      flush_cycles_d    = sat_inc(flush_cycles_q, flushDecode);
      load_use_events_d = sat_inc(load_use_events_q, w_load_use_stall);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q    <= 16'd0;
         flush_cycles_q    <= 16'd0;
         load_use_events_q <= 16'd0;
      end else begin
         stall_cycles_q    <= stall_cycles_d;
         flush_cycles_q    <= flush_cycles_d;
         load_use_events_q <= load_use_events_d;
      end
   end

   assign stallCycles   = reset ? 16'd0 : stall_cycles_q;
   assign flushCycles   = reset ? 16'd0 : flush_cycles_q;
   assign loadUseEvents = reset ? 16'd0 : load_use_events_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_controller
//  Purpose  : Directed vector table, hand-written corner sequences and a
//             randomized run against a behavioural model of the hazard unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_controller;

   localparam int BP = 2;
   localparam int TO = 4;

   localparam logic [4:0] E_NONE  = 5'b00000;
   localparam logic [4:0] E_STALL = 5'b11100;  // {sF,sD,sE,fD,fE}
   localparam logic [4:0] E_FLUSH = 5'b00011;
   localparam logic [4:0] E_LU    = 5'b11001;

   typedef struct {
      logic       rst, mr, we;
      logic [3:0] rd, rs1;
      logic       u1;
      logic [3:0] rs2;
      logic       u2, pc, req, rdy;
      logic [4:0] e;
      logic       to;
      logic [1:0] bs;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] idRs1 = '0, idRs2 = '0, exRd = '0;
   logic       idUsesRs1 = 1'b0, idUsesRs2 = 1'b0, exRegWe = 1'b0, exMemRead = 1'b0;
   logic       exPcWe = 1'b0, memReq = 1'b0, memReady = 1'b0;
   logic       stallFetch, stallDecode, stallExecute, flushDecode, flushExecute, memTimeout;
   logic [1:0] busyState;
`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stallCycles, flushCycles, loadUseEvents;
`endif

   always #5 clk = ~clk;

   pipeline_hazard_controller #(
      .BRANCH_PENALTY(BP), .MEM_TIMEOUT(TO), .REG_IDX_W(4)
   ) dut (
      .clk(clk), .reset(reset),
      .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
      .exRd(exRd), .exRegWe(exRegWe), .exMemRead(exMemRead), .exPcWe(exPcWe),
      .memReq(memReq), .memReady(memReady),
      .stallFetch(stallFetch), .stallDecode(stallDecode), .stallExecute(stallExecute),
      .flushDecode(flushDecode), .flushExecute(flushExecute),
      .memTimeout(memTimeout), .busyState(busyState)
`ifdef HAZARD_PERF_CNT_EN
      , .stallCycles(stallCycles), .flushCycles(flushCycles), .loadUseEvents(loadUseEvents)
`endif
   );

   int errors = 0;
   int checks = 0;

   // Model: waiting flag + stalled-cycle run length, and owed flush cycles
   bit         m_wait  = 0;
   int         m_run   = 0;
   int         m_flush = 0;
   bit         m_to    = 0;
   int         m_sc = 0, m_fc = 0, m_lc = 0;
   logic [4:0] m_e;
   logic       m_to_o;
   logic [1:0] m_bs;
   int         m_sc_o, m_fc_o, m_lc_o;

   function automatic int sat(input int x);
      return (x < 65535) ? x + 1 : x;
   endfunction

   function automatic vec_t mk(input logic rst, mr, we, input logic [3:0] rd, rs1,
                               input logic u1, input logic [3:0] rs2,
                               input logic u2, pc, req, rdy,
                               input logic [4:0] e, input logic to, input logic [1:0] bs);
      vec_t v;
      v.rst = rst; v.mr = mr; v.we = we; v.rd = rd; v.rs1 = rs1; v.u1 = u1;
      v.rs2 = rs2; v.u2 = u2; v.pc = pc; v.req = req; v.rdy = rdy;
      v.e = e; v.to = to; v.bs = bs;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_eval();
      logic busy, lu;
      busy   = memReq & ~memReady;
      lu     = exMemRead & exRegWe &
               ((idUsesRs1 & (idRs1 == exRd)) | (idUsesRs2 & (idRs2 == exRd)));
      m_e    = E_NONE;
      m_to_o = m_to;
      m_bs   = m_wait ? 2'd1 : ((m_flush > 0) ? 2'd2 : 2'd0);
      m_sc_o = m_sc; m_fc_o = m_fc; m_lc_o = m_lc;
      if (reset) begin
         m_to_o = 0; m_bs = 0; m_sc_o = 0; m_fc_o = 0; m_lc_o = 0;
         m_wait = 0; m_run = 0; m_flush = 0; m_to = 0; m_sc = 0; m_fc = 0; m_lc = 0;
      end else begin
         if (m_wait) begin
            if (!memReady) begin
               m_e = E_STALL;
               if (m_run == TO) begin
                  m_to   = 1;
                  m_wait = 0;
               end else begin
                  m_run++;
               end
            end else begin
               m_wait = 0;
            end
         end else if (busy) begin
            m_e = E_STALL; m_wait = 1; m_run = 1;
         end else if (exPcWe) begin
            m_e = E_FLUSH; m_flush = BP - 1;
         end else if (m_flush > 0) begin
            m_e = E_FLUSH; m_flush--;
         end else if (lu) begin
            m_e = E_LU; m_lc = sat(m_lc);
         end
         if (m_e[4]) m_sc = sat(m_sc);
         if (m_e[1]) m_fc = sat(m_fc);
      end
   endtask

   task automatic step(input vec_t v, input bit use_model, input string tag);
      logic [4:0] ef;
      logic       et;
      logic [1:0] eb;
      @(negedge clk);
      reset = v.rst; exMemRead = v.mr; exRegWe = v.we; exRd = v.rd;
      idRs1 = v.rs1; idUsesRs1 = v.u1; idRs2 = v.rs2; idUsesRs2 = v.u2;
      exPcWe = v.pc; memReq = v.req; memReady = v.rdy;
      #2;
      model_eval();
      if (use_model) begin
         ef = m_e; et = m_to_o; eb = m_bs;
      end else begin
         ef = v.e; et = v.to; eb = v.bs;
      end
      check($sformatf("%s flags", tag),
            {11'd0, stallFetch, stallDecode, stallExecute, flushDecode, flushExecute}, {11'd0, ef});
      check($sformatf("%s memTimeout", tag), {15'd0, memTimeout}, {15'd0, et});
      check($sformatf("%s busyState", tag), {14'd0, busyState}, {14'd0, eb});
`ifdef HAZARD_PERF_CNT_EN
      check($sformatf("%s stallCycles", tag), stallCycles, 16'(m_sc_o));
      check($sformatf("%s flushCycles", tag), flushCycles, 16'(m_fc_o));
      check($sformatf("%s loadUseEvents", tag), loadUseEvents, 16'(m_lc_o));
`endif
   endtask

   initial begin
      vec_t tbl[$];
      vec_t idle;
      vec_t rv;
      idle = mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,0,0, E_NONE,0,2'd0);

      tbl.push_back(mk(1, 0,0,4'd0,4'd0,0,4'd0,0, 0,1,0, E_NONE, 0,2'd0));
      tbl.push_back(mk(1, 0,0,4'd0,4'd0,0,4'd0,0, 1,0,0, E_NONE, 0,2'd0));
      tbl.push_back(idle);
      tbl.push_back(mk(0, 1,1,4'd3,4'd3,1,4'd0,0, 0,0,0, E_LU,   0,2'd0));
      tbl.push_back(idle);
      tbl.push_back(mk(0, 1,1,4'd3,4'd3,0,4'd0,0, 0,0,0, E_NONE, 0,2'd0));
      tbl.push_back(mk(0, 1,1,4'd5,4'd0,0,4'd5,1, 0,0,0, E_LU,   0,2'd0));
      tbl.push_back(mk(0, 1,0,4'd5,4'd0,0,4'd5,1, 0,0,0, E_NONE, 0,2'd0));
      tbl.push_back(mk(0, 1,1,4'd0,4'd0,1,4'd0,0, 0,0,0, E_LU,   0,2'd0));
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 1,0,0, E_FLUSH,0,2'd0));
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,0,0, E_FLUSH,0,2'd2));
      tbl.push_back(idle);
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,1,0, E_STALL,0,2'd0));
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,1,0, E_STALL,0,2'd1));
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,1,1, E_NONE, 0,2'd1));
      tbl.push_back(idle);
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,1,1, E_NONE, 0,2'd0));
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 1,0,0, E_FLUSH,0,2'd0));
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,1,0, E_STALL,0,2'd2));
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,1,0, E_STALL,0,2'd1));
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,1,0, E_STALL,0,2'd1));
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,1,1, E_NONE, 0,2'd1));
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,0,0, E_FLUSH,0,2'd2));
      tbl.push_back(idle);
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 1,1,0, E_STALL,0,2'd0));
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 1,1,0, E_STALL,0,2'd1));
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,1,1, E_NONE, 0,2'd1));
      tbl.push_back(idle);
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 1,0,0, E_FLUSH,0,2'd0));
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 1,0,0, E_FLUSH,0,2'd2));
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,0,0, E_FLUSH,0,2'd2));
      tbl.push_back(idle);
      tbl.push_back(mk(0, 1,1,4'd3,4'd3,1,4'd0,0, 1,0,0, E_FLUSH,0,2'd0));
      tbl.push_back(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,0,0, E_FLUSH,0,2'd2));
      tbl.push_back(idle);

      foreach (tbl[i]) step(tbl[i], 1'b0, $sformatf("row%0d", i));

      // Timeout: stalls through the entry cycle plus TO wait cycles, then sticky flag
      for (int k = 1; k <= TO + 1; k++)
         step(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,1,0, E_STALL,0,(k == 1) ? 2'd0 : 2'd1),
              1'b0, $sformatf("timeout%0d", k));
      step(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,1,0, E_STALL,1,2'd0), 1'b0, "timeout_rearm");
      step(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,0,1, E_NONE, 1,2'd1), 1'b0, "timeout_ready");
      step(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,0,0, E_NONE, 1,2'd0), 1'b0, "timeout_sticky");

      // Reset in the middle of a memory wait
      step(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,1,0, E_STALL,1,2'd0), 1'b0, "rstwait_enter");
      step(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,1,0, E_STALL,1,2'd1), 1'b0, "rstwait_wait");
      step(mk(1, 0,0,4'd0,4'd0,0,4'd0,0, 0,1,0, E_NONE, 0,2'd0), 1'b0, "rstwait_rst");
      step(mk(0, 0,0,4'd0,4'd0,0,4'd0,0, 0,0,0, E_NONE, 0,2'd0), 1'b0, "rstwait_after");

      // Randomized run against the model
      step(mk(1, 0,0,4'd0,4'd0,0,4'd0,0, 0,0,0, E_NONE,0,2'd0), 1'b1, "rnd_rst");
      for (int i = 0; i < 3000; i++) begin
         rv = mk(($urandom_range(0, 149) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) == 0),
                 E_NONE, 1'b0, 2'd0);
         step(rv, 1'b1, $sformatf("rnd%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
